// File: rtl/water_level_tracker.sv
// Tank water level tracker: counts slow new_clock edges in the system clock domain and
// steps the level up (fill) or down (irrigation, cleaning) with saturation at both ends.
module water_level_tracker #(
    parameter int LEVEL_W    = 4,
    parameter int LEVEL_MAX  = 15,
    parameter int LOW_MARK   = 3,
    parameter int FILL_STEP  = 1,
    parameter int DRAIN_STEP = 1,
    parameter int CLEAN_STEP = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_in,
    input  logic [1:0]         rega,
    input  logic [1:0]         limpeza,
    input  logic               erro,
    output logic [LEVEL_W-1:0] nivel,
    output logic               cheio,
    output logic               vazio,
    output logic               baixo,
    output logic               falta_agua,
    output logic [2:0]         estado
);

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_DRIP      = 3'd1,
        ST_SPRINKLER = 3'd2,
        ST_CLEAN     = 3'd3,
        ST_ERROR     = 3'd4
    } mode_t;

    localparam int SUM_W = LEVEL_W + 1;
    localparam logic [SUM_W-1:0]   MAX_EXT   = SUM_W'(LEVEL_MAX);
    localparam logic [SUM_W-1:0]   FILL_EXT  = SUM_W'(FILL_STEP);
    localparam logic [SUM_W-1:0]   DRAIN_EXT = SUM_W'(DRAIN_STEP);
    localparam logic [SUM_W-1:0]   CLEAN_EXT = SUM_W'(CLEAN_STEP);
    localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LOW_LVL   = LEVEL_W'(LOW_MARK);

    // Tick path: sync and history flops reset high so a high tick_in at release is not a tick.
    logic sync1_q, sync2_q, hist_q;
    logic tick_p;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= tick_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign tick_p = sync2_q & ~hist_q;

    // Mode FSM: state register, next-state decode, output.
    mode_t estado_q, mode_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= ST_FILL;
        end else begin
            estado_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = ST_FILL;
        if (erro) begin
            mode_d = ST_ERROR;
        end else if (rega == 2'b01) begin
            mode_d = ST_DRIP;
        end else if (rega == 2'b10) begin
            mode_d = ST_SPRINKLER;
        end else if (limpeza[1]) begin
            mode_d = ST_CLEAN;
        end
    end

    always_comb begin
        estado = estado_q;
    end

    // Level datapath; the step uses the combinational mode of the tick_p cycle.
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               falta_q, falta_d;
    logic [SUM_W-1:0]   level_ext;
    logic [SUM_W-1:0]   fill_sum;
    logic [SUM_W-1:0]   drain_step;

    assign level_ext  = {1'b0, level_q};
    assign fill_sum   = level_ext + FILL_EXT;
    assign drain_step = (mode_d == ST_CLEAN) ? CLEAN_EXT : DRAIN_EXT;

    always_comb begin
        level_d = level_q;
        falta_d = falta_q;
        if (tick_p) begin
            unique case (mode_d)
                ST_FILL: begin
                    level_d = (fill_sum > MAX_EXT) ? MAX_LVL : fill_sum[LEVEL_W-1:0];
                    falta_d = 1'b0;
                end
                ST_DRIP, ST_SPRINKLER, ST_CLEAN: begin
                    if (level_ext < drain_step) begin
                        level_d = '0;
                        falta_d = 1'b1;
                    end else begin
                        level_d = level_q - drain_step[LEVEL_W-1:0];
                    end
                end
                default: begin
                    level_d = level_q;
                    falta_d = falta_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            falta_q <= 1'b0;
        end else begin
            level_q <= level_d;
            falta_q <= falta_d;
        end
    end

    always_comb begin
        nivel      = level_q;
        cheio      = (level_q == MAX_LVL);
        vazio      = (level_q == '0);
        baixo      = (level_q <= LOW_LVL);
        falta_agua = falta_q;
    end

endmodule

// File: tb/tb_water_level_tracker.sv
// Bench for water_level_tracker: directed scenarios followed by randomized ticks, all
// checked against an integer model of the tank.
module tb_water_level_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_in;
    logic [1:0] rega;
    logic [1:0] limpeza;
    logic       erro;
    logic [3:0] nivel;
    logic       cheio, vazio, baixo, falta_agua;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;
    int m_lvl = 0;
    int m_falta = 0;

    water_level_tracker dut (
        .clock      (clock),
        .reset      (reset),
        .tick_in    (tick_in),
        .rega       (rega),
        .limpeza    (limpeza),
        .erro       (erro),
        .nivel      (nivel),
        .cheio      (cheio),
        .vazio      (vazio),
        .baixo      (baixo),
        .falta_agua (falta_agua),
        .estado     (estado)
    );

    always #5 clock = ~clock;

    function automatic int mode_of();
        if (erro) return 4;
        if (rega == 2'b01) return 1;
        if (rega == 2'b10) return 2;
        if (limpeza[1]) return 3;
        return 0;
    endfunction

    // Model of one counted tick, from the tank rules.
    task automatic model_tick();
        int m;
        m = mode_of();
        if (m == 0) begin
            m_lvl = (m_lvl + 1 > 15) ? 15 : m_lvl + 1;
            m_falta = 0;
        end else if (m != 4) begin
            int step;
            step = (m == 3) ? 2 : 1;
            if (m_lvl < step) begin
                m_lvl = 0;
                m_falta = 1;
            end else begin
                m_lvl = m_lvl - step;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".nivel"}, int'(nivel), m_lvl);
        chk({tag, ".cheio"}, int'(cheio), (m_lvl == 15) ? 1 : 0);
        chk({tag, ".vazio"}, int'(vazio), (m_lvl == 0) ? 1 : 0);
        chk({tag, ".baixo"}, int'(baixo), (m_lvl <= 3) ? 1 : 0);
        chk({tag, ".falta"}, int'(falta_agua), m_falta);
        chk({tag, ".estado"}, int'(estado), mode_of());
    endtask

    // One tick_in pulse; the level is checked on the falling edge after it updates.
    task automatic do_tick(input string tag, input int hi, input int lo, input bit drop_erro);
        @(negedge clock);
        tick_in = 1'b1;
        repeat (2) @(negedge clock);
        if (drop_erro) erro = 1'b0;
        @(negedge clock);
        model_tick();
        chk_all(tag);
        repeat (hi - 3) @(negedge clock);
        tick_in = 1'b0;
        repeat (lo) @(negedge clock);
        chk({tag, ".hold"}, int'(nivel), m_lvl);
    endtask

    task automatic set_mode(input logic [1:0] r, input logic [1:0] l, input logic e);
        rega = r;
        limpeza = l;
        erro = e;
    endtask

    initial begin
        reset = 1'b1;
        tick_in = 1'b0;
        set_mode(2'b00, 2'b00, 1'b0);
        repeat (3) @(negedge clock);
        chk_all("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk_all("post_reset");

        for (int i = 0; i < 5; i++) do_tick("fill5", 8, 8, 1'b0);
        for (int i = 0; i < 20; i++) do_tick("fill_sat", 4, 4, 1'b0);

        set_mode(2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) do_tick("drip", 4, 4, 1'b0);
        set_mode(2'b00, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) do_tick("clean", 4, 4, 1'b0);
        chk("lvl_after_clean", int'(nivel), 5);

        set_mode(2'b10, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) do_tick("to_one", 4, 4, 1'b0);
        set_mode(2'b00, 2'b10, 1'b0);
        do_tick("clean_clamp", 4, 4, 1'b0);
        set_mode(2'b11, 2'b00, 1'b0);
        do_tick("refill", 4, 4, 1'b0);

        for (int i = 0; i < 3; i++) do_tick("prefill", 4, 4, 1'b0);
        set_mode(2'b10, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) do_tick("error_hold", 4, 4, 1'b0);
        do_tick("erro_drop", 4, 4, 1'b1);

        for (int i = 0; i < 60; i++) begin
            int hi, lo;
            hi = $urandom_range(8, 3);
            lo = $urandom_range(6, 2);
            set_mode(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                     ($urandom_range(7, 0) == 0));
            do_tick("rand", hi, lo, 1'b0);
        end

        set_mode(2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) do_tick("pre_rst", 4, 4, 1'b0);
        @(negedge clock);
        tick_in = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        m_lvl = 0;
        m_falta = 0;
        chk("rst_async.nivel", int'(nivel), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk_all("rst_high_release");
        tick_in = 1'b0;
        repeat (4) @(negedge clock);
        do_tick("after_rst", 4, 4, 1'b0);
        chk("after_rst.one", int'(nivel), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
